alu64_exec_unit: RTL
====================

ALU64_EXEC_UNIT -- requirements
Module: alu64_exec_unit

Interface
REQ-001 Parameter: WIDTH, default 64, operand/result width in bits; all widths below use WIDTH=64.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, synchronous, active-low.
REQ-004 in_valid  input  1  operation request present.
REQ-005 in_ready  output  1  unit accepts a request this cycle.
REQ-006 alu_fun  input  2  operation: 0=ADD, 1=SUB, 2=AND, 3=XOR.
REQ-007 val_a  input  64  signed operand A.
REQ-008 val_b  input  64  signed operand B.
REQ-009 set_cc  input  1  update condition codes with this operation.
REQ-010 out_valid  output  1  result register holds an unconsumed result.
REQ-011 out_ready  input  1  consumer takes the result this cycle.
REQ-012 val_e  output  64  registered signed result.
REQ-013 cc  output  3  condition codes {ZF,SF,OF}, registered.
REQ-014 op_count  output  16  number of operations accepted since reset.

Function
REQ-015 Accept = in_valid && in_ready; in_ready = !out_valid || out_ready (combinational, one-entry output buffer).
REQ-016 Latency: an operation accepted in cycle N appears on val_e with out_valid=1 in cycle N+1.
REQ-017 ADD: val_e = val_b + val_a, modulo 2^64.
REQ-018 SUB: val_e = val_b - val_a, modulo 2^64.
REQ-019 AND: val_e = val_b & val_a, bitwise.
REQ-020 XOR: val_e = val_b ^ val_a, bitwise.
REQ-021 On accept with set_cc=1: ZF = (result==0); SF = result[63]; OF as follows.
REQ-022 OF for ADD = (a[63]==b[63]) && (result[63]!=a[63]).
REQ-023 OF for SUB = (a[63]!=b[63]) && (result[63]!=b[63]).
REQ-024 OF for AND/XOR = 0.
REQ-025 On accept with set_cc=0, or no accept, cc holds its value.
REQ-026 cc updates in the same edge as val_e (visible in cycle N+1).
REQ-027 out_valid rises on accept; falls when out_ready=1 with no accept in the same cycle; stays 1 on simultaneous drain and accept (back-to-back, one result per cycle).
REQ-028 While out_valid=1 and out_ready=0: in_ready=0, val_e and cc hold stable, no request accepted.
REQ-029 out_ready while out_valid=0 has no effect.
REQ-030 op_count increments by 1 per accept; wraps 0xFFFF -> 0x0000.
REQ-031 val_e holds its last value after drain; it is meaningful only while out_valid=1.
REQ-032 In-flight state: one result register, one cc register; no other storage.

Reset
REQ-033 When rst_n=0 at a rising edge: out_valid=0, val_e=0, cc=3'b100 (ZF=1,SF=0,OF=0), op_count=0.
REQ-034 Reset overrides any simultaneous accept or drain; a pending result is discarded.
REQ-035 During reset, in_ready follows REQ-015 (=1, since out_valid=0).

Verification
REQ-036 Reset, then AND a=0x5555, b=0xAAAA, set_cc=1 -> next cycle val_e=0, cc=100, out_valid=1, op_count=1.
REQ-037 ADD a=0x7FFFFFFFFFFFFFFF, b=1, set_cc=1 -> val_e=0x8000000000000000, cc=011 (SF=1,OF=1).
REQ-038 SUB a=5, b=3, set_cc=0 after prior cc=100 -> val_e=-2 (0xFFFFFFFFFFFFFFFE), cc stays 100.
REQ-039 out_ready=0 for 3 cycles with result pending, in_valid=1 -> in_ready=0, val_e stable, op_count unchanged; then out_ready=1 -> new op accepted same cycle, next result next cycle.
REQ-040 Stream 4 XORs with out_ready=1 constantly -> 4 results on 4 consecutive cycles, out_valid continuously 1, op_count=4.
REQ-041 Assert rst_n=0 while out_valid=1 and in_valid=1 -> next cycle out_valid=0, val_e=0, cc=100, op_count=0.

Source files
------------

// File: rtl/alu64_exec_unit_if.sv
// -----------------------------------------------------------------------------
// alu64_exec_unit_if
//   Bundles the request and result channels of alu64_exec_unit.
//
//   Request channel (master -> slave):
//     in_valid   operation request present
//     alu_fun    operation select: 0=ADD, 1=SUB, 2=AND, 3=XOR
//     val_a      operand A (signed, WIDTH bits)
//     val_b      operand B (signed, WIDTH bits)
//     set_cc     update condition codes with this operation
//     in_ready   (slave -> master) unit accepts a request this cycle
//
//   Result channel (slave -> master):
//     out_valid  result register holds an unconsumed result
//     val_e      registered result (WIDTH bits)
//     cc         registered condition codes {ZF,SF,OF}
//     op_count   number of operations accepted since reset (wraps)
//     out_ready  (master -> slave) consumer takes the result this cycle
//
//   The master modport is the requester/consumer side; slave is the unit.
// -----------------------------------------------------------------------------
interface alu64_exec_unit_if #(
    parameter int WIDTH = 64
);
    logic             in_valid;
    logic             in_ready;
    logic [1:0]       alu_fun;
    logic [WIDTH-1:0] val_a;
    logic [WIDTH-1:0] val_b;
    logic             set_cc;

    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] val_e;
    logic [2:0]       cc;
    logic [15:0]      op_count;

    modport master (
        output in_valid,
        output alu_fun,
        output val_a,
        output val_b,
        output set_cc,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  val_e,
        input  cc,
        input  op_count
    );

    modport slave (
        input  in_valid,
        input  alu_fun,
        input  val_a,
        input  val_b,
        input  set_cc,
        input  out_ready,
        output in_ready,
        output out_valid,
        output val_e,
        output cc,
        output op_count
    );
endinterface

// File: rtl/alu64_exec_unit.sv
// -----------------------------------------------------------------------------
// alu64_exec_unit
//   Single-stage integer execute unit. Computes ADD/SUB/AND/XOR on two signed
//   operands and registers the result together with condition codes. The
//   result register doubles as a one-entry output buffer with valid/ready
//   handshakes on both sides, so a streaming consumer gets one result per
//   cycle and a stalled consumer back-pressures the requester.
//
//   Ports:
//     clk    single clock, all state updates on the rising edge
//     rst_n  synchronous active-low reset
//     bus    alu64_exec_unit_if.slave (request + result channels)
//
//   Result conventions:
//     ADD: val_e = val_b + val_a      SUB: val_e = val_b - val_a
//     AND: val_e = val_b & val_a      XOR: val_e = val_b ^ val_a
//     cc = {ZF,SF,OF}, updated only by accepted operations with set_cc=1.
//     Reset state: out_valid=0, val_e=0, cc=3'b100, op_count=0.
// -----------------------------------------------------------------------------
module alu64_exec_unit #(
    parameter int WIDTH = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    alu64_exec_unit_if.slave  bus
);

    localparam int MSB = WIDTH - 1;

    typedef enum logic [1:0] {
        FUN_ADD = 2'd0,
        FUN_SUB = 2'd1,
        FUN_AND = 2'd2,
        FUN_XOR = 2'd3
    } alu_fun_e;

    // Condition codes after reset: ZF set, SF/OF clear.
    localparam logic [2:0] CC_RESET = 3'b100;

    // -------------------------------------------------------------------------
    // State: one result register, one cc register, valid flag, op counter.
    // -------------------------------------------------------------------------
    logic             out_valid_q;
    logic [WIDTH-1:0] val_e_q;
    logic [2:0]       cc_q;
    logic [15:0]      op_count_q;

    // -------------------------------------------------------------------------
    // Handshake
    // -------------------------------------------------------------------------
    alu_fun_e         fun;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             accept;

    assign fun = alu_fun_e'(bus.alu_fun);
    assign a   = bus.val_a;
    assign b   = bus.val_b;

    // The buffer can take a new entry when it is empty or is being drained
    // in the same cycle; this is what allows back-to-back results.
    assign bus.in_ready = !out_valid_q || bus.out_ready;
    assign accept       = bus.in_valid && bus.in_ready;

    // -------------------------------------------------------------------------
    // Datapath
    // -------------------------------------------------------------------------
    logic [WIDTH-1:0] result;
    logic             of_flag;
    logic             zf_flag;
    logic             sf_flag;

    always_comb begin
        // NOTE: every output of a combinational block gets a default before the
        // case so that no path leaves it unassigned, which would infer a latch.
        result  = '0;
        of_flag = 1'b0;
        case (fun)
            FUN_ADD: begin
                result  = b + a;
                // Signed overflow: operands agree in sign, result does not.
                of_flag = (a[MSB] == b[MSB]) && (result[MSB] != a[MSB]);
            end
            FUN_SUB: begin
                result  = b - a;
                // b - a overflows when signs differ and the result loses b's sign.
                of_flag = (a[MSB] != b[MSB]) && (result[MSB] != b[MSB]);
            end
            FUN_AND: begin
                result  = b & a;
                of_flag = 1'b0;
            end
            FUN_XOR: begin
                result  = b ^ a;
                of_flag = 1'b0;
            end
            default: begin
                result  = '0;
                of_flag = 1'b0;
            end
        endcase
    end

    assign zf_flag = (result == '0);
    assign sf_flag = result[MSB];

    // -------------------------------------------------------------------------
    // Registers. Reset is sampled on the clock edge and wins over any
    // simultaneous accept or drain, discarding a pending result.
    // -------------------------------------------------------------------------
    // NOTE: sequential state is written only with non-blocking assignments so
    // every register samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            val_e_q     <= '0;
            cc_q        <= CC_RESET;
            op_count_q  <= '0;
        end else begin
            if (accept) begin
                // Accept has priority over drain: a drain in the same cycle
                // frees the slot that the new result immediately refills.
                out_valid_q <= 1'b1;
                val_e_q     <= result;
                op_count_q  <= op_count_q + 16'd1;
                if (bus.set_cc) begin
                    cc_q <= {zf_flag, sf_flag, of_flag};
                end
            end else if (bus.out_ready) begin
                // val_e keeps its last value after drain; only valid drops.
                out_valid_q <= 1'b0;
            end
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.val_e     = val_e_q;
    assign bus.cc        = cc_q;
    assign bus.op_count  = op_count_q;

endmodule
